// File: rtl/fan_pkg.sv
// Shared encodings for the fan controller: mode/state values, off-timer
// selection codes, preset pulse bit positions and the speed LED mapping.
package fan_pkg;

    // o_mode encodings
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_LOW  = 2'd1;
    localparam logic [1:0] MODE_MID  = 2'd2;
    localparam logic [1:0] MODE_HIGH = 2'd3;

    // o_timer_sel encodings
    localparam logic [1:0] TSEL_NONE = 2'd0;
    localparam logic [1:0] TSEL_10   = 2'd1;
    localparam logic [1:0] TSEL_20   = 2'd2;
    localparam logic [1:0] TSEL_30   = 2'd3;

    // o_fantime bit indices
    localparam int unsigned FT_10 = 0;
    localparam int unsigned FT_20 = 1;
    localparam int unsigned FT_30 = 2;

    // FSM states share the o_mode encoding so the state drives o_mode directly
    typedef enum logic [1:0] {
        S_OFF  = MODE_OFF,
        S_LOW  = MODE_LOW,
        S_MID  = MODE_MID,
        S_HIGH = MODE_HIGH
    } state_t;

    // One-hot speed LEDs {HIGH, MID, LOW}; all dark when off
    function automatic logic [2:0] speed_led(input state_t st);
        case (st)
            S_LOW:   speed_led = 3'b001;
            S_MID:   speed_led = 3'b010;
            S_HIGH:  speed_led = 3'b100;
            default: speed_led = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Motor PWM generator: free-running period counter, duty reload only at the
// counter wrap (glitch-free), and a compare against the applied duty.
// Optional soft start when FAN_SOFT_START_EN is defined: rising targets are
// approached one count per RAMP_STEP cycles; falling targets apply at the wrap.
module fan_pwm_gen #(
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned RAMP_STEP  = 1000,
    localparam int unsigned DutyW     = $clog2(PWM_PERIOD + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [DutyW-1:0] i_target,
    output logic             o_pwm
);

    if (PWM_PERIOD < 2 || RAMP_STEP < 1) begin : g_param_check
        $error("fan_pwm_gen: PWM_PERIOD must be >= 2 and RAMP_STEP >= 1");
    end

    logic [DutyW-1:0] cnt_q;
    logic [DutyW-1:0] applied_q;
    logic [DutyW-1:0] reload_val;
    logic             wrap;

    assign wrap = (cnt_q == DutyW'(PWM_PERIOD - 1));

    // Period counter 0..PWM_PERIOD-1
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DutyW'(1);
        end
    end

`ifdef FAN_SOFT_START_EN
    localparam int unsigned RampW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

    logic [RampW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [DutyW-1:0] level_q, level_d;

    // Ramp level: climbs one count per RAMP_STEP cycles, drops to target at once
    always_comb begin
        ramp_cnt_d = '0;
        level_d    = level_q;
        if (level_q < i_target) begin
            if (ramp_cnt_q == RampW'(RAMP_STEP - 1)) begin
                level_d = level_q + DutyW'(1);
            end else begin
                ramp_cnt_d = ramp_cnt_q + RampW'(1);
            end
        end else begin
            level_d = i_target;
        end
    end

    // Ramp state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ramp_cnt_q <= '0;
            level_q    <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
            level_q    <= level_d;
        end
    end

    assign reload_val = level_q;
`else
    assign reload_val = i_target;
`endif

    // Applied duty changes only on the wrap so no period is cut short
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            applied_q <= '0;
        end else if (wrap) begin
            applied_q <= reload_val;
        end
    end

    assign o_pwm = (cnt_q < applied_q);

endmodule

// File: rtl/fan_mode_controller.sv
// Fan sequencing controller: power/speed FSM, off-timer selection with
// one-cycle preset pulses, armed expiry detection on the timer count, status
// LEDs and motor PWM via fan_pwm_gen.
// Build option: define FAN_SOFT_START_EN to ramp rising duty (soft start).
module fan_mode_controller
    import fan_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned DUTY_LOW   = 30,
    parameter int unsigned DUTY_MID   = 60,
    parameter int unsigned DUTY_HIGH  = 90,
    parameter int unsigned RAMP_STEP  = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_power,
    input  logic       i_btn_speed,
    input  logic       i_btn_timer,
    input  logic [6:0] i_timer_sec,
    input  logic [6:0] i_timer_msec,
    output logic [2:0] o_fantime,
    output logic [1:0] o_mode,
    output logic [1:0] o_timer_sel,
    output logic       o_pwm,
    output logic [3:0] o_led
);

    localparam int unsigned DutyW = $clog2(PWM_PERIOD + 1);

    state_t           state_q, state_d;
    logic [1:0]       tsel_q, tsel_d;
    logic [1:0]       tsel_inc;
    logic             armed_q, armed_d;
    logic [2:0]       fantime_q, fantime_d;
    logic             expiry;
    logic [DutyW-1:0] target_duty;

    assign tsel_inc = tsel_q + 2'd1;

    // Armed gate stops stale zero counts reading as expiry before the preset lands
    assign expiry = armed_q && (i_timer_sec == 7'd0) && (i_timer_msec == 7'd0);

    // Next state: power beats expiry, expiry beats speed/timer, speed+timer combine
    always_comb begin
        state_d   = state_q;
        tsel_d    = tsel_q;
        armed_d   = armed_q;
        fantime_d = 3'b000;
        if (i_btn_power) begin
            if (state_q == S_OFF) begin
                state_d = S_LOW;
            end else begin
                state_d = S_OFF;
                tsel_d  = TSEL_NONE;
                armed_d = 1'b0;
            end
        end else if (expiry) begin
            state_d = S_OFF;
            tsel_d  = TSEL_NONE;
            armed_d = 1'b0;
        end else if (state_q != S_OFF) begin
            if (tsel_q != TSEL_NONE && i_timer_sec != 7'd0) begin
                armed_d = 1'b1;
            end
            if (i_btn_speed) begin
                case (state_q)
                    S_LOW:   state_d = S_MID;
                    S_MID:   state_d = S_HIGH;
                    default: state_d = S_LOW;
                endcase
            end
            if (i_btn_timer) begin
                tsel_d  = tsel_inc;
                armed_d = 1'b0;
                case (tsel_inc)
                    TSEL_10: fantime_d[FT_10] = 1'b1;
                    TSEL_20: fantime_d[FT_20] = 1'b1;
                    TSEL_30: fantime_d[FT_30] = 1'b1;
                    default: fantime_d = 3'b000;
                endcase
            end
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_OFF;
            tsel_q    <= TSEL_NONE;
            armed_q   <= 1'b0;
            fantime_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            tsel_q    <= tsel_d;
            armed_q   <= armed_d;
            fantime_q <= fantime_d;
        end
    end

    // Target duty per speed
    always_comb begin
        target_duty = '0;
        case (state_q)
            S_LOW:   target_duty = DutyW'(DUTY_LOW);
            S_MID:   target_duty = DutyW'(DUTY_MID);
            S_HIGH:  target_duty = DutyW'(DUTY_HIGH);
            default: target_duty = '0;
        endcase
    end

    assign o_mode      = state_q;
    assign o_timer_sel = tsel_q;
    assign o_fantime   = fantime_q;
    assign o_led       = {(tsel_q != TSEL_NONE), speed_led(state_q)};

    fan_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP)
    ) u_pwm (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_target (target_duty),
        .o_pwm    (o_pwm)
    );

endmodule

// File: tb/tb_fan_mode_controller.sv
// Self-checking bench for fan_mode_controller: a table of single-cycle
// vectors for the FSM/timer behaviour, then hand-written PWM and reset sequences.
module tb_fan_mode_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_power, btn_speed, btn_timer;
    logic [6:0] tsec, tmsec;
    logic [2:0] fantime;
    logic [1:0] mode, timer_sel;
    logic       pwm;
    logic [3:0] led;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fan_mode_controller #(
        .PWM_PERIOD (100),
        .DUTY_LOW   (30),
        .DUTY_MID   (60),
        .DUTY_HIGH  (90),
        .RAMP_STEP  (1000)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_btn_power  (btn_power),
        .i_btn_speed  (btn_speed),
        .i_btn_timer  (btn_timer),
        .i_timer_sec  (tsec),
        .i_timer_msec (tmsec),
        .o_fantime    (fantime),
        .o_mode       (mode),
        .o_timer_sel  (timer_sel),
        .o_pwm        (pwm),
        .o_led        (led)
    );

    typedef struct {
        string      name;
        logic       pw, sp, tm;
        logic [6:0] sec, msec;
        logic [1:0] mode;
        logic [1:0] tsel;
        logic [2:0] ft;
        logic [3:0] led;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input string name, input logic pw, sp, tm,
                       input logic [6:0] sec, msec, input logic [1:0] m, ts,
                       input logic [2:0] ft, input logic [3:0] l);
        vec_t v;
        v.name = name; v.pw = pw; v.sp = sp; v.tm = tm; v.sec = sec; v.msec = msec;
        v.mode = m; v.tsel = ts; v.ft = ft; v.led = l;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Press buttons for one cycle; returns at the negedge after the capturing edge
    task automatic press(input logic pw, sp, tm);
        @(negedge clk);
        btn_power = pw; btn_speed = sp; btn_timer = tm;
        @(negedge clk);
        btn_power = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0;
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (pwm) n++;
        end
    endtask

    // Waits for a low->high transition on o_pwm, bounded
    task automatic wait_rise(input int bound, output int waited, output bit ok);
        logic prev;
        prev   = pwm;
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < bound) begin
            @(negedge clk);
            waited++;
            if (pwm && !prev) ok = 1'b1;
            prev = pwm;
        end
    endtask

    initial begin
        int  n_high, waited;
        bit  ok;

        rst = 1'b1;
        btn_power = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0;
        tsec = 7'd0; tmsec = 7'd0;
        repeat (3) @(negedge clk);
        check("rst_mode", int'(mode), 0);
        check("rst_tsel", int'(timer_sel), 0);
        check("rst_fantime", int'(fantime), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_led", int'(led), 0);
        rst = 1'b0;

        //   name            pw sp tm sec msec  mode tsel ft      led
        add("idle_off",      0, 0, 0, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("spd_in_off",    0, 1, 0, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("tmr_in_off",    0, 0, 1, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("power_on",      1, 0, 0, 0,  0,    1,   0,   3'b000, 4'b0001);
        add("spd_mid",       0, 1, 0, 0,  0,    2,   0,   3'b000, 4'b0010);
        add("spd_high",      0, 1, 0, 0,  0,    3,   0,   3'b000, 4'b0100);
        add("spd_wrap_low",  0, 1, 0, 0,  0,    1,   0,   3'b000, 4'b0001);
        add("tmr_10",        0, 0, 1, 0,  0,    1,   1,   3'b001, 4'b1001);
        add("ft_one_cycle",  0, 0, 0, 0,  0,    1,   1,   3'b000, 4'b1001);
        add("stale_zero",    0, 0, 0, 0,  0,    1,   1,   3'b000, 4'b1001);
        add("tmr_20",        0, 0, 1, 0,  0,    1,   2,   3'b010, 4'b1001);
        add("arm_sec20",     0, 0, 0, 20, 0,    1,   2,   3'b000, 4'b1001);
        add("msec_nonzero",  0, 0, 0, 0,  50,   1,   2,   3'b000, 4'b1001);
        add("expire",        0, 0, 0, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("power_on2",     1, 0, 0, 0,  0,    1,   0,   3'b000, 4'b0001);
        add("spd_mid2",      0, 1, 0, 0,  0,    2,   0,   3'b000, 4'b0010);
        add("pw_sp_mid",     1, 1, 0, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("power_on3",     1, 0, 0, 0,  0,    1,   0,   3'b000, 4'b0001);
        add("tmr_10b",       0, 0, 1, 0,  0,    1,   1,   3'b001, 4'b1001);
        add("arm_sec5",      0, 0, 0, 5,  0,    1,   1,   3'b000, 4'b1001);
        add("exp_and_spd",   0, 1, 0, 0,  0,    0,   0,   3'b000, 4'b0000);
        add("power_on4",     1, 0, 0, 0,  0,    1,   0,   3'b000, 4'b0001);
        add("spd_and_tmr",   0, 1, 1, 0,  0,    2,   1,   3'b001, 4'b1010);
        add("tmr_20b",       0, 0, 1, 0,  0,    2,   2,   3'b010, 4'b1010);
        add("tmr_30",        0, 0, 1, 0,  0,    2,   3,   3'b100, 4'b1010);
        add("tmr_none",      0, 0, 1, 0,  0,    2,   0,   3'b000, 4'b0010);
        add("no_arm_tsel0",  0, 0, 0, 9,  0,    2,   0,   3'b000, 4'b0010);
        add("no_exp_tsel0",  0, 0, 0, 0,  0,    2,   0,   3'b000, 4'b0010);
        add("tmr_10c",       0, 0, 1, 30, 0,    2,   1,   3'b001, 4'b1010);
        add("arm_sec30",     0, 0, 0, 30, 0,    2,   1,   3'b000, 4'b1010);
        add("power_off",     1, 0, 0, 0,  0,    0,   0,   3'b000, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            btn_power = vecs[i].pw; btn_speed = vecs[i].sp; btn_timer = vecs[i].tm;
            tsec = vecs[i].sec; tmsec = vecs[i].msec;
            @(negedge clk);
            btn_power = 1'b0; btn_speed = 1'b0; btn_timer = 1'b0;
            check({vecs[i].name, "_mode"}, int'(mode), int'(vecs[i].mode));
            check({vecs[i].name, "_tsel"}, int'(timer_sel), int'(vecs[i].tsel));
            check({vecs[i].name, "_ft"}, int'(fantime), int'(vecs[i].ft));
            check({vecs[i].name, "_led"}, int'(led), int'(vecs[i].led));
        end
        tsec = 7'd0; tmsec = 7'd0;

`ifndef FAN_SOFT_START_EN
        // LOW duty: first pulse within one period, then 30 high per 100
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        wait_rise(101, waited, ok);
        check("low_first_rise", int'(ok), 1);
        if (ok) begin
            n_high = 1;
            repeat (99) begin
                @(negedge clk);
                if (pwm) n_high++;
            end
            check("low_duty", n_high, 30);
        end
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        count_high(n_high);
        check("high_duty", n_high, 90);
        press(1'b1, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        count_high(n_high);
        check("off_duty", n_high, 0);
`endif

        // Reset asserted during a PWM high phase clears outputs at once
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
`ifdef FAN_SOFT_START_EN
        repeat (2500) @(negedge clk);
`endif
        wait_rise(3000, waited, ok);
        check("pwm_rise_seen", int'(ok), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_led", int'(led), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
